iq_mod: RTL and testbench

- I/Q modulator: the transmit-side counterpart of the sonar demodulator.
- Accepts interleaved baseband I/Q sample pairs per channel (I beat, then Q beat) on an AXI-Stream slave.
- Computes one real passband sample per pair: out = (I*LUT_I[ph] + Q*LUT_Q[ph]) >>> 24, using a per-channel 5-entry carrier phase LUT.
- Sits between the ping/waveform generator and the DAC stream.

---
 rtl/sonar_dsp_pkg.sv | 41 ++++
 rtl/iq_mod_mac.sv | 44 ++++
 rtl/iq_mod.sv | 148 ++++++++++++++
 tb/tb_iq_mod.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_dsp_pkg.sv
// Shared sonar DSP definitions: carrier phase LUTs, sample type and the
// one-hot state encoding of the I/Q modulator.
package sonar_dsp_pkg;

    localparam int PHASE_N  = 5;
    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [2:0]                 phase_t;

    typedef enum logic [4:0] {
        ST_RX_I = 5'b00001,
        ST_RX_Q = 5'b00010,
        ST_MUL  = 5'b00100,
        ST_SUM  = 5'b01000,
        ST_TX   = 5'b10000
    } iq_mod_state_t;

    // Q1.23 carrier samples; |LUT_I|+|LUT_Q| < 2^24 at every phase.
    localparam sample_t LUT_I [PHASE_N] = '{
        24'sd0, 24'sd7978039, 24'sd4930699, -24'sd4930701, -24'sd7978041
    };
    localparam sample_t LUT_Q [PHASE_N] = '{
        24'sd8388607, 24'sd2592221, -24'sd6786527, -24'sd6786527, 24'sd2592221
    };

    function automatic sample_t lut_cos(input phase_t p);
        return (p < phase_t'(PHASE_N)) ? LUT_I[p] : '0;
    endfunction

    function automatic sample_t lut_sin(input phase_t p);
        return (p < phase_t'(PHASE_N)) ? LUT_Q[p] : '0;
    endfunction

    function automatic phase_t phase_add(input phase_t p, input phase_t step);
        logic [3:0] s;
        s = {1'b0, p} + {1'b0, step};
        return (s >= 4'(PHASE_N)) ? 3'(s - 4'(PHASE_N)) : s[2:0];
    endfunction

endpackage

// File: rtl/iq_mod_mac.sv
// Two-stage modulator datapath: register both products, then sum,
// arithmetic-shift by 24 and keep the low 24 bits.
module iq_mod_mac
    import sonar_dsp_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_en_mul,
    input  logic    i_en_sum,
    input  sample_t i_i,
    input  sample_t i_q,
    input  sample_t i_cos,
    input  sample_t i_sin,
    output sample_t o_result
);

    logic signed [47:0] r_prod_i;
    logic signed [47:0] r_prod_q;
    logic signed [48:0] w_sum;
    sample_t            r_result;

    assign w_sum = 49'(r_prod_i) + 49'(r_prod_q);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod_i <= '0;
            r_prod_q <= '0;
            r_result <= '0;
        end else begin
            if (i_en_mul) begin
                r_prod_i <= i_i * i_cos;
                r_prod_q <= i_q * i_sin;
            end
            if (i_en_sum) begin
                r_result <= 24'(w_sum >>> 24);
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/iq_mod.sv
// I/Q modulator: one passband sample per interleaved I/Q pair, per-channel
// carrier phase. Optional IQ_MOD_PHASE_SYNC_EN adds a phase_sync input.
module iq_mod
    import sonar_dsp_pkg::*;
#(
    parameter int CH_W       = 2,
    parameter int PHASE_STEP = 2
) (
    input  logic            s_axis_aclk,
    input  logic            s_axis_areset,
    input  logic [23:0]     s_axis_tdata,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [CH_W:0]   s_axis_tuser,
    output logic [23:0]     m_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [CH_W-1:0] m_axis_tuser,
    output logic            proto_err
`ifdef IQ_MOD_PHASE_SYNC_EN
    ,
    input  logic            phase_sync
`endif
);

    localparam int N_CH = 2**CH_W;

    iq_mod_state_t   r_state, w_next_state;
    sample_t         r_i, r_q, r_cos, r_sin;
    sample_t         w_result;
    logic [CH_W-1:0] r_ch, r_tuser;
    phase_t          r_phase [N_CH];
    phase_t          w_lut_idx;
    logic            r_proto_err;
    logic            w_ld_i, w_ld_q, w_proto, w_advance, w_sync;

    wire [CH_W-1:0] w_ch_in = s_axis_tuser[CH_W:1];
    wire            w_is_q  = s_axis_tuser[0];
    wire            w_beat  = s_axis_tvalid & s_axis_tready;

`ifdef IQ_MOD_PHASE_SYNC_EN
    assign w_sync = phase_sync;
`else
    assign w_sync = 1'b0;
`endif

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) r_state <= ST_RX_I;
        else               r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_ld_i       = 1'b0;
        w_ld_q       = 1'b0;
        w_proto      = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            ST_RX_I: if (w_beat) begin
                if (!w_is_q) begin
                    w_ld_i       = 1'b1;
                    w_next_state = ST_RX_Q;
                end else begin
                    w_proto = 1'b1;
                end
            end
            ST_RX_Q: if (w_beat) begin
                if (!w_is_q) begin
                    w_ld_i  = 1'b1;
                    w_proto = 1'b1;
                end else if (w_ch_in == r_ch) begin
                    w_ld_q       = 1'b1;
                    w_next_state = ST_MUL;
                end else begin
                    w_proto      = 1'b1;
                    w_next_state = ST_RX_I;
                end
            end
            ST_MUL: w_next_state = ST_SUM;
            ST_SUM: w_next_state = ST_TX;
            ST_TX: if (m_axis_tready) begin
                w_advance    = 1'b1;
                w_next_state = ST_RX_I;
            end
            default: w_next_state = ST_RX_I;
        endcase
    end

    // A sync arriving with the Q beat already selects phase 0 for that pair.
    assign w_lut_idx = w_sync ? '0 : r_phase[r_ch];

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_i         <= '0;
            r_q         <= '0;
            r_ch        <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_tuser     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_proto;
            if (w_ld_i) begin
                r_i  <= s_axis_tdata;
                r_ch <= w_ch_in;
            end
            if (w_ld_q) begin
                r_q   <= s_axis_tdata;
                r_cos <= lut_cos(w_lut_idx);
                r_sin <= lut_sin(w_lut_idx);
            end
            if (r_state == ST_SUM) r_tuser <= r_ch;
        end
    end

    // NOTE: the phase table is reset like any register because every channel
    // must start its carrier at phase 0 after reset.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            for (int k = 0; k < N_CH; k++) r_phase[k] <= '0;
        end else if (w_sync) begin
            for (int k = 0; k < N_CH; k++) r_phase[k] <= '0;
        end else if (w_advance) begin
            r_phase[r_ch] <= phase_add(r_phase[r_ch], 3'(PHASE_STEP));
        end
    end

    iq_mod_mac u_mac (
        .clk      (s_axis_aclk),
        .rst      (s_axis_areset),
        .i_en_mul (r_state == ST_MUL),
        .i_en_sum (r_state == ST_SUM),
        .i_i      (r_i),
        .i_q      (r_q),
        .i_cos    (r_cos),
        .i_sin    (r_sin),
        .o_result (w_result)
    );

    assign s_axis_tready = !s_axis_areset && (r_state == ST_RX_I || r_state == ST_RX_Q);
    assign m_axis_tvalid = (r_state == ST_TX);
    assign m_axis_tdata  = w_result;
    assign m_axis_tuser  = r_tuser;
    assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_iq_mod.sv
// Scoreboard bench for iq_mod; exercises phase_sync when IQ_MOD_PHASE_SYNC_EN is set.
module tb_iq_mod;

    localparam int CH_W = 2;
    localparam longint LI [5] = '{0, 7978039, 4930699, -4930701, -7978041};
    localparam longint LQ [5] = '{8388607, 2592221, -6786527, -6786527, 2592221};

    typedef struct {
        logic [23:0] data;
        logic [1:0]  ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [2:0]  s_tuser;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [1:0]  m_tuser;
    logic        perr;
`ifdef IQ_MOD_PHASE_SYNC_EN
    logic        psync;
`endif

    int   n_total = 0;
    int   n_bad   = 0;
    int   n_proto = 0;
    int   ph [4];
    exp_t sb [$];

    always #5 clk = ~clk;

    iq_mod #(.CH_W(CH_W), .PHASE_STEP(2)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .proto_err     (perr)
`ifdef IQ_MOD_PHASE_SYNC_EN
        ,
        .phase_sync    (psync)
`endif
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (perr === 1'b1) n_proto++;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", longint'(m_tdata), -1);
            end else begin
                e = sb.pop_front();
                check("tdata", longint'(m_tdata), longint'(e.data));
                check("tuser", longint'(m_tuser), longint'(e.ch));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic void model_push(input int ch, input logic [23:0] i, input logic [23:0] q);
        longint acc;
        exp_t   e;
        acc = longint'($signed(i)) * LI[ph[ch]] + longint'($signed(q)) * LQ[ph[ch]];
        acc = acc >>> 24;
        e.data = acc[23:0];
        e.ch   = 2'(ch);
        sb.push_back(e);
        ph[ch] = (ph[ch] + 2) % 5;
    endfunction

    task automatic send(input int ch, input bit q, input logic [23:0] d);
        int guard = 0;
        while (s_tready !== 1'b1 && guard < 50) begin
            tick(1);
            guard++;
        end
        if (guard >= 50) check("send_timeout", 0, 1);
        s_tvalid = 1'b1;
        s_tuser  = {2'(ch), q};
        s_tdata  = d;
        tick(1);
        s_tvalid = 1'b0;
    endtask

    task automatic pair(input int ch, input logic [23:0] i, input logic [23:0] q);
        send(ch, 1'b0, i);
        send(ch, 1'b1, q);
        model_push(ch, i, q);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic wait_tvalid();
        int guard = 0;
        while (m_tvalid !== 1'b1 && guard < 20) begin
            tick(1);
            guard++;
        end
        check("tvalid_timeout", guard < 20, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) ph[k] = 0;
        tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          p0;
        logic [23:0] a, b, q;
        logic [23:0] held;

        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tuser  = '0;
        m_tready = 1'b1;
`ifdef IQ_MOD_PHASE_SYNC_EN
        psync    = 1'b0;
`endif
        for (int k = 0; k < 4; k++) ph[k] = 0;
        tick(2);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_proto", perr, 0);
        rst = 1'b0;
        tick(1);
        check("idle_s_tready", s_tready, 1);

        // Single pair: latency and known result.
        send(0, 1'b0, 24'd0);
        send(0, 1'b1, 24'd4194304);
        model_push(0, 24'd0, 24'd4194304);
        lat = 1;
        while (m_tvalid !== 1'b1 && lat < 20) begin
            tick(1);
            lat++;
        end
        check("latency", lat, 3);
        check("t1_data", m_tdata, 2097151);
        check("t1_user", m_tuser, 0);
        drain();

        // Full phase cycle from phase 0, then one more pair back at phase 0.
        do_reset();
        send(0, 1'b0, 24'd0);
        send(0, 1'b1, 24'd8388607);
        model_push(0, 24'd0, 24'd8388607);
        wait_tvalid();
        check("t2_first", m_tdata, 4194303);
        for (int k = 0; k < 4; k++) pair(0, 24'd0, 24'd8388607);
        pair(0, 24'($urandom), 24'($urandom));
        drain();
        check("t2_phase_wrap", ph[0], 2);

        // Interleaved channels with random samples.
        for (int k = 0; k < 12; k++) begin
            pair(k % 3, 24'($urandom), 24'($urandom));
        end
        drain();

        // Q beat while waiting for I.
        p0 = n_proto;
        send(1, 1'b1, 24'h123456);
        tick(3);
        check("proto_q_in_rxi", n_proto - p0, 1);

        // I, I, Q: second I wins.
        p0 = n_proto;
        a = 24'($urandom);
        b = 24'($urandom);
        q = 24'($urandom);
        send(2, 1'b0, a);
        send(2, 1'b0, b);
        send(2, 1'b1, q);
        model_push(2, b, q);
        drain();
        check("proto_double_i", n_proto - p0, 1);

        // Channel mismatch drops the pair.
        p0 = n_proto;
        send(0, 1'b0, 24'($urandom));
        send(1, 1'b1, 24'($urandom));
        tick(4);
        check("proto_ch_mismatch", n_proto - p0, 1);
        check("mismatch_no_out", m_tvalid, 0);

        // Back-pressure: output held, input stalled, phase advances once.
        m_tready = 1'b0;
        pair(3, 24'($urandom), 24'($urandom));
        wait_tvalid();
        held = sb[0].data;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("bp_tdata", m_tdata, held);
            check("bp_tvalid", m_tvalid, 1);
            check("bp_s_tready", s_tready, 0);
        end
        m_tready = 1'b1;
        drain();
        pair(3, 24'($urandom), 24'($urandom));
        drain();

        // Reset while the pair is in the multiply stage.
        send(0, 1'b0, 24'($urandom));
        send(0, 1'b1, 24'($urandom));
        rst = 1'b1;
        #1;
        check("rst_mid_tvalid", m_tvalid, 0);
        check("rst_mid_s_tready", s_tready, 0);
        tick(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) ph[k] = 0;
        tick(5);
        check("rst_mid_no_out", m_tvalid, 0);
        pair(0, 24'($urandom), 24'($urandom));
        pair(3, 24'($urandom), 24'($urandom));
        drain();

`ifdef IQ_MOD_PHASE_SYNC_EN
        pair(1, 24'($urandom), 24'($urandom));
        pair(2, 24'($urandom), 24'($urandom));
        drain();
        psync = 1'b1;
        tick(1);
        psync = 1'b0;
        for (int k = 0; k < 4; k++) ph[k] = 0;
        pair(1, 24'($urandom), 24'($urandom));
        pair(2, 24'($urandom), 24'($urandom));
        drain();
`endif

        tick(3);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
